// File: rtl/tri_raster_ctrl_if.sv
// Handshake bundle for the raster sequencer: triangle command in, fragment stream out.
// The controller side uses the slave modport; the command source / pixel writer side uses master.
interface tri_raster_ctrl_if #(parameter int COORD_W = 10);
   logic               tri_valid;
   logic               tri_ready;
   logic [COORD_W-1:0] in_v1x, in_v1y, in_v2x, in_v2y, in_v3x, in_v3y;
   logic               pix_valid;
   logic               pix_ready;
   logic [COORD_W-1:0] pix_x, pix_y;

   modport master (
      output tri_valid, in_v1x, in_v1y, in_v2x, in_v2y, in_v3x, in_v3y, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y
   );

   modport slave (
      input  tri_valid, in_v1x, in_v1y, in_v2x, in_v2y, in_v3x, in_v3y, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y
   );
endinterface

// File: rtl/tri_raster_ctrl.sv
// Walks the screen-clamped bounding box of one triangle in raster order, feeding an
// external point-in-triangle unit and emitting covered pixels as a valid/ready stream.
module tri_raster_ctrl #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   tri_raster_ctrl_if.slave   bus,
   output logic [COORD_W-1:0] tst_v1x, tst_v1y, tst_v2x, tst_v2y, tst_v3x, tst_v3y,
   output logic [COORD_W-1:0] tst_x,
   output logic [COORD_W-1:0] tst_y,
   output logic               tst_active,
   input  logic               tst_present,
   output logic               busy,
   output logic               done,
   output logic [18:0]        frag_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BBOX = 2'd1;
   localparam logic [1:0] SCAN = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [COORD_W-1:0] XLIM = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] YLIM = COORD_W'(V_RES - 1);

   logic [1:0]         state;
   logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
   logic [COORD_W-1:0] cx, cy;
   logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
   logic               pix_fire, adv;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   always_comb begin
      bx_min = min3(tst_v1x, tst_v2x, tst_v3x);
      bx_max = max3(tst_v1x, tst_v2x, tst_v3x);
      by_min = min3(tst_v1y, tst_v2y, tst_v3y);
      by_max = max3(tst_v1y, tst_v2y, tst_v3y);
   end

   assign tst_active    = (state == SCAN);
   assign tst_x         = cx;
   assign tst_y         = cy;
   assign bus.pix_x     = cx;
   assign bus.pix_y     = cy;
   assign bus.pix_valid = tst_active & tst_present;
   assign bus.tri_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   // A covered pixel holds the cursor until the writer takes it; misses move on at once.
   assign pix_fire = bus.pix_valid & bus.pix_ready;
   assign adv      = tst_active & (~tst_present | bus.pix_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tst_v1x    <= '0;
         tst_v1y    <= '0;
         tst_v2x    <= '0;
         tst_v2y    <= '0;
         tst_v3x    <= '0;
         tst_v3y    <= '0;
         xmin       <= '0;
         xmax       <= '0;
         ymin       <= '0;
         ymax       <= '0;
         cx         <= '0;
         cy         <= '0;
         frag_count <= '0;
      end else begin
         case (state)
            IDLE: if (bus.tri_valid) begin
               tst_v1x    <= bus.in_v1x;
               tst_v1y    <= bus.in_v1y;
               tst_v2x    <= bus.in_v2x;
               tst_v2y    <= bus.in_v2y;
               tst_v3x    <= bus.in_v3x;
               tst_v3y    <= bus.in_v3y;
               frag_count <= '0;
               state      <= BBOX;
            end
            BBOX: begin
               // Clamped max stays >= min whenever the box is non-empty, so the scan cannot wrap.
               xmin <= bx_min;
               ymin <= by_min;
               xmax <= (bx_max > XLIM) ? XLIM : bx_max;
               ymax <= (by_max > YLIM) ? YLIM : by_max;
               if (bx_min > XLIM || by_min > YLIM) begin
                  state <= DONE;
               end else begin
                  cx    <= bx_min;
                  cy    <= by_min;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (pix_fire) frag_count <= frag_count + 19'd1;
               if (adv) begin
                  if (cx < xmax) begin
                     cx <= cx + 1'b1;
                  end else if (cy < ymax) begin
                     cx <= xmin;
                     cy <= cy + 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tri_raster_ctrl.md
Name: tri_raster_ctrl

Overview:
Sequencer for the combinational point-in-triangle test. Accepts one triangle per valid/ready handshake, then walks its screen-clamped bounding box in raster order, driving one candidate pixel per cycle into an external is-in-triangle unit. Every covered pixel is emitted on a valid/ready fragment stream to the framebuffer writer. Sits between the triangle setup/command queue and the pixel write path.

Parameters:
H_RES, 640, horizontal resolution; x coordinates clamp to H_RES-1
V_RES, 480, vertical resolution; y coordinates clamp to V_RES-1
COORD_W, 10, coordinate width in bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tri_valid  in  1  triangle offered
tri_ready  out  1  controller can accept a triangle
in_v1x, in_v1y, in_v2x, in_v2y, in_v3x, in_v3y  in  COORD_W each  unsigned vertex coordinates
tst_v1x, tst_v1y, tst_v2x, tst_v2y, tst_v3x, tst_v3y  out  COORD_W each  latched vertices to the test unit
tst_x, tst_y  out  COORD_W each  candidate pixel to the test unit
tst_active  out  1  candidate valid to the test unit
tst_present  in  1  test result for the current candidate, combinational, same cycle
pix_valid  out  1  fragment valid
pix_ready  in  1  fragment consumer ready
pix_x, pix_y  out  COORD_W each  fragment coordinate
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a triangle finishes
frag_count  out  19  fragments emitted for the current or last triangle

Behaviour:
- Reset values: state IDLE; tri_ready=1, tst_active=0, pix_valid=0, busy=0, done=0, frag_count=0. tst_* vertices and tst_x/tst_y reset to 0.
- A reset asserted mid-triangle abandons it immediately. Any pending fragment is dropped; no done pulse is produced.
- **IDLE**
  - tri_ready=1.
  - Accept on tri_valid & tri_ready: latch the six vertices into tst_v*, clear frag_count, go to BBOX.
- **BBOX** (exactly 1 cycle)
  - Register xmin/xmax/ymin/ymax as the min/max of the latched vertices.
  - Clamp xmax to H_RES-1 and ymax to V_RES-1.
  - If xmin > H_RES-1 or ymin > V_RES-1, the box is empty: go to DONE.
  - Otherwise load cursor = (xmin, ymin) and go to SCAN.
- **SCAN**
  - tst_active=1; tst_x/tst_y = cursor; pix_x/pix_y = cursor.
  - pix_valid = tst_present (combinational).
  - Cursor advances when tst_present=0, or when pix_valid & pix_ready.
  - While pix_valid=1 and pix_ready=0, the cursor and pix_x/pix_y hold. pix_valid must not drop until the handshake completes.
  - frag_count increments on each pix_valid & pix_ready.
  - Advance rule: if x < xmax then x+1; else x = xmin and y+1.
  - Advancing from (xmax, ymax) goes to DONE instead.
  - Throughput: one candidate per cycle when pix_ready=1.
  - Single-pixel box (xmin=xmax, ymin=ymax): one SCAN cycle when not stalled.
- **DONE** (1 cycle)
  - done=1, tst_active=0, pix_valid=0; then go to IDLE.
  - tri_ready is 0 in DONE, so the next accept happens no earlier than the IDLE cycle.
- tri_ready=0 in BBOX, SCAN and DONE. tri_valid in those states is ignored and must be held by the source.
- Degenerate (zero-area) triangles are scanned normally. Coverage is whatever tst_present reports.
- Arithmetic: all comparisons are unsigned COORD_W. The cursor never exceeds the clamped max, so it cannot wrap.
- Latency for a triangle with no stalls: accept cycle + 1 (BBOX) + box_w*box_h (SCAN) + 1 (DONE).

Test Plan:
- Triangle (10,10),(13,10),(10,13), pix_ready=1, checked against the reference test unit: 16 SCAN cycles; fragments in raster order; frag_count equals the reference coverage count (10 pixels including edges); done pulses 18 cycles after accept.
- Same triangle with pix_ready toggling 1/0 every cycle: fragments identical and in the same order; pix_x/pix_y stable while stalled; no duplicated or lost fragments.
- Triangle (630,470),(700,470),(630,500): box clamped to x 630..639, y 470..479; no tst_x > 639 and no tst_y > 479 ever observed.
- Triangle (700,10),(800,10),(700,50): empty box; BBOX then DONE; no tst_active cycle; frag_count=0; done pulses 2 cycles after accept.
- Single point (5,5),(5,5),(5,5): one SCAN cycle at (5,5); frag_count matches tst_present; then done.
- rst pulsed mid-SCAN while pix_valid=1: the next cycle shows IDLE, tri_ready=1, pix_valid=0, no done pulse; a following triangle then processes normally.
